seven_segment_scanner: RTL and testbench

Parametrised multiplexed seven-segment display scanner for the alarm clock front panel. Drives DIGIT_NUM common-anode digits from a packed BCD word, with per-digit decimal points, per-digit blink, leading-zero blanking and PWM brightness. Inputs are captured into shadow registers once per frame, so a time update never tears mid-scan. It sits between the timekeeping/alarm logic and the board pins.

---
 rtl/seven_segment_scanner.sv | 145 ++++++++++++++
 tb/tb_seven_segment_scanner.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scanner.sv
// Multiplexed common-anode seven-segment scanner: frame-latched shadow inputs,
// per-digit blink and decimal point, leading-zero blanking and PWM brightness.
module seven_segment_scanner #(
  parameter int CLK_IN          = 5000000,
  parameter int DIGIT_NUM       = 4,
  parameter int DISPLAY_REFRESH = 5000,
  parameter int BLINK_HZ        = 2,
  parameter int PWM_BITS        = 3
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset_n,
  input  logic [4*DIGIT_NUM-1:0]   i_BCD_Num,
  input  logic [DIGIT_NUM-1:0]     i_DP,
  input  logic [DIGIT_NUM-1:0]     i_Blink_Mask,
  input  logic                     i_Blank_Leading,
  input  logic [PWM_BITS-1:0]      i_Brightness,
  output logic [6:0]               o_Segments,
  output logic                     o_DP,
  output logic [DIGIT_NUM-1:0]     o_Anodes,
  output logic                     o_Frame_Done
);

  localparam int unsigned SLOT_CYCLES = CLK_IN / DISPLAY_REFRESH;
  localparam int unsigned BLINK_HALF  = CLK_IN / (2 * BLINK_HZ);
  localparam int unsigned NUM_DIGITS  = DIGIT_NUM;
  localparam int unsigned CW = $clog2(SLOT_CYCLES + 1);
  localparam int unsigned DW = (DIGIT_NUM > 1) ? $clog2(DIGIT_NUM) : 1;
  localparam int unsigned BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  logic [CW-1:0]          slot_cnt;
  logic [CW-1:0]          on_cycles;
  logic [DW-1:0]          digit_idx;
  logic [BW-1:0]          blink_cnt;
  logic                   blink_phase;
  logic                   loaded;

  logic [4*DIGIT_NUM-1:0] sh_bcd;
  logic [DIGIT_NUM-1:0]   sh_dp;
  logic [DIGIT_NUM-1:0]   sh_blink;
  logic                   sh_blank_en;

  logic                   slot_last;
  logic                   digit_last;
  logic                   frame_end;
  logic [DIGIT_NUM-1:0]   lead_blank;
  logic                   run;
  int unsigned            k;
  logic [3:0]             cur_nibble;
  logic                   cur_dp;
  logic                   lit;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  assign slot_last  = (slot_cnt == CW'(SLOT_CYCLES - 1));
  assign digit_last = (digit_idx == DW'(DIGIT_NUM - 1));
  assign frame_end  = slot_last && digit_last;

  // Leading run walks from the leftmost digit down; digit 0 is never part of it.
  always_comb begin
    lead_blank = '0;
    run        = sh_blank_en;
    k          = 0;
    for (int unsigned i = 0; i < NUM_DIGITS - 1; i++) begin
      k = NUM_DIGITS - 1 - i;
      if (run && sh_bcd[k*4 +: 4] == 4'd0 && !sh_dp[k])
        lead_blank[k] = 1'b1;
      else
        run = 1'b0;
    end
  end

  assign cur_nibble = sh_bcd[{digit_idx, 2'b00} +: 4];
  assign cur_dp     = sh_dp[digit_idx];
  assign lit = (slot_cnt != '0) && (slot_cnt < on_cycles) &&
               !(blink_phase && sh_blink[digit_idx]) && !lead_blank[digit_idx];

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      slot_cnt     <= '0;
      digit_idx    <= '0;
      blink_cnt    <= '0;
      blink_phase  <= 1'b0;
      loaded       <= 1'b0;
      sh_bcd       <= '0;
      sh_dp        <= '0;
      sh_blink     <= '0;
      sh_blank_en  <= 1'b0;
      on_cycles    <= '0;
      o_Segments   <= 7'h7F;
      o_DP         <= 1'b1;
      o_Anodes     <= '1;
      o_Frame_Done <= 1'b0;
    end else begin
      if (slot_last) begin
        slot_cnt  <= '0;
        digit_idx <= digit_last ? '0 : digit_idx + 1'b1;
      end else begin
        slot_cnt  <= slot_cnt + 1'b1;
      end

      if (blink_cnt == BW'(BLINK_HALF - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt   <= blink_cnt + 1'b1;
      end

      // Shadows change only when slot 0 of digit 0 is next, which is always dark.
      if (!loaded || frame_end) begin
        loaded      <= 1'b1;
        sh_bcd      <= i_BCD_Num;
        sh_dp       <= i_DP;
        sh_blink    <= i_Blink_Mask;
        sh_blank_en <= i_Blank_Leading;
        on_cycles   <= CW'(((32'(i_Brightness) + 32'd1) * SLOT_CYCLES) >> PWM_BITS);
      end

      o_Frame_Done <= frame_end;
      if (lit) begin
        o_Anodes   <= ~(DIGIT_NUM'(1) << digit_idx);
        o_Segments <= seg_decode(cur_nibble);
        o_DP       <= ~cur_dp;
      end else begin
        o_Anodes   <= '1;
        o_Segments <= 7'h7F;
        o_DP       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Scoreboard bench for seven_segment_scanner: a cycle-index reference model
// queues the expected pin state each edge and a monitor compares it.
module tb_seven_segment_scanner;

  localparam int unsigned N      = 4;
  localparam int unsigned PB     = 3;
  localparam int unsigned CLKHZ  = 4000;
  localparam int unsigned REFHZ  = 100;
  localparam int unsigned BLKHZ  = 7;
  localparam int unsigned SLOT   = CLKHZ / REFHZ;
  localparam int unsigned FRAME  = N * SLOT;
  localparam int unsigned BH     = CLKHZ / (2 * BLKHZ);

  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
    7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};

  typedef struct packed {
    logic [6:0]   seg;
    logic         dp;
    logic [N-1:0] an;
    logic         fd;
  } out_t;

  localparam out_t DARK = '{seg: 7'h7F, dp: 1'b1, an: '1, fd: 1'b0};

  logic            clk = 1'b0;
  logic            rst_n;
  logic [4*N-1:0]  bcd;
  logic [N-1:0]    dp_in;
  logic [N-1:0]    mask;
  logic            blank_en;
  logic [PB-1:0]   br;
  logic [6:0]      seg;
  logic            dp_out;
  logic [N-1:0]    an;
  logic            fd;

  int   checks = 0;
  int   errors = 0;
  bit   done   = 1'b0;
  out_t exp_q[$];

  logic [4*N-1:0] sh_bcd;
  logic [N-1:0]   sh_dp;
  logic [N-1:0]   sh_mask;
  logic           sh_blank;
  logic [PB-1:0]  sh_br;
  int unsigned    kcyc;

  seven_segment_scanner #(
    .CLK_IN(CLKHZ), .DIGIT_NUM(N), .DISPLAY_REFRESH(REFHZ),
    .BLINK_HZ(BLKHZ), .PWM_BITS(PB)
  ) dut (
    .i_Clk(clk), .i_Reset_n(rst_n), .i_BCD_Num(bcd), .i_DP(dp_in),
    .i_Blink_Mask(mask), .i_Blank_Leading(blank_en), .i_Brightness(br),
    .o_Segments(seg), .o_DP(dp_out), .o_Anodes(an), .o_Frame_Done(fd)
  );

  always #5 clk = ~clk;

  // Expected pins for the edge taken while kk edges have elapsed since reset release.
  function automatic out_t predict(int unsigned kk);
    int unsigned s, d, on;
    bit phase, blanked, lit;
    out_t o;
    s     = kk % SLOT;
    d     = (kk / SLOT) % N;
    on    = ((int'(sh_br) + 1) * SLOT) / (1 << PB);
    phase = ((kk / BH) % 2) == 1;
    blanked = 1'b0;
    if (sh_blank && d > 0) begin
      blanked = 1'b1;
      for (int unsigned j = d; j < N; j++)
        if (sh_bcd[j*4 +: 4] != 4'd0 || sh_dp[j]) blanked = 1'b0;
    end
    lit = (s >= 1) && (s < on) && !(phase && sh_mask[d]) && !blanked;
    o = DARK;
    if (lit) begin
      o.seg   = GLYPH[sh_bcd[d*4 +: 4]];
      o.dp    = ~sh_dp[d];
      o.an[d] = 1'b0;
    end
    o.fd = (kk % FRAME) == FRAME - 1;
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference model: pushes one expectation per clock edge.
  initial begin
    kcyc = 0; sh_bcd = '0; sh_dp = '0; sh_mask = '0; sh_blank = 1'b0; sh_br = '0;
    forever begin
      @(posedge clk);
      if (done) break;
      if (!rst_n) begin
        exp_q.push_back(DARK);
        kcyc = 0; sh_bcd = '0; sh_dp = '0; sh_mask = '0; sh_blank = 1'b0; sh_br = '0;
      end else begin
        exp_q.push_back(predict(kcyc));
        if (kcyc == 0 || (kcyc % FRAME) == FRAME - 1) begin
          sh_bcd = bcd; sh_dp = dp_in; sh_mask = mask; sh_blank = blank_en; sh_br = br;
        end
        kcyc++;
      end
    end
  end

  // Monitor: the DUT presents a new pin state every edge.
  initial begin
    out_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (done) break;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scan: no expectation queued at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        a = '{seg: seg, dp: dp_out, an: an, fd: fd};
        if (a !== e) begin
          errors++;
          $display("FAIL scan t=%0t: got seg=%b dp=%b an=%b fd=%b expected seg=%b dp=%b an=%b fd=%b",
                   $time, a.seg, a.dp, a.an, a.fd, e.seg, e.dp, e.an, e.fd);
        end
      end
    end
  end

  task automatic run_cycles(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; bcd = 16'h1259; dp_in = '0; mask = '0; blank_en = 1'b0; br = 3'd7;
    run_cycles(3);
    check("reset_seg", 32'(seg), 32'h7F);
    check("reset_dp", 32'(dp_out), 32'h1);
    check("reset_an", 32'(an), 32'hF);
    check("reset_fd", 32'(fd), 32'h0);
    rst_n = 1'b1;

    // Full brightness 1259, then a mid-frame change that must wait for the next frame.
    run_cycles(2 * FRAME + 60);
    bcd = 16'h0000;
    run_cycles(2 * FRAME);

    bcd = 16'h0050; blank_en = 1'b1;
    run_cycles(2 * FRAME);
    dp_in = 4'b1000;
    run_cycles(2 * FRAME);

    dp_in = '0; blank_en = 1'b0; br = 3'd0; bcd = 16'h3A7F;
    run_cycles(2 * FRAME);

    br = 3'd5; bcd = 16'h8642; mask = 4'b0011;
    run_cycles(5 * FRAME);

    // Asynchronous reset mid-slot: pins must go dark before the next edge.
    run_cycles(57);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_an", 32'(an), 32'hF);
    check("async_rst_seg", 32'(seg), 32'h7F);
    check("async_rst_dp", 32'(dp_out), 32'h1);
    check("async_rst_fd", 32'(fd), 32'h0);
    run_cycles(2);
    bcd = 16'h0907; mask = '0; br = 3'd7;
    rst_n = 1'b1;
    run_cycles(2 * FRAME);

    for (int unsigned c = 0; c < 30 * FRAME; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0) begin
        for (int unsigned j = 0; j < N; j++)
          bcd[j*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        dp_in    = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
        mask     = N'($urandom);
        blank_en = 1'($urandom);
        br       = PB'($urandom);
      end
    end

    @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
